// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the clock-ratio divide controller.
package div_ctrl_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

endpackage

// File: rtl/div_ctrl_counter.sv
// Loadable down-counter that stops at zero; load takes priority over decrement.
module load_down_counter
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/div_ctrl.sv
// Divide-by-N run controller: one-shot or periodic tick generation with abort,
// period counting and rejection of a zero divide ratio.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             busy_o,
  output logic             tick_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0] periods_o
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] periods_q, periods_d;
  logic             err_q, err_d;

  logic             accept_c;
  logic             cnt_zero_c;
  logic             cnt_load_c;
  logic             cnt_en_c;
  logic [WIDTH-1:0] cnt_load_val_c;

  assign accept_c = (state_q == ST_IDLE) && start_i && !stop_i && (div_i != '0);
  assign tick_o   = (state_q == ST_RUN) && cnt_zero_c && !stop_i;

  // Reload on acceptance, and on every tick while running periodically.
  assign cnt_load_c     = accept_c || (tick_o && (mode_q == MODE_PERIODIC));
  assign cnt_load_val_c = accept_c ? (div_i - WIDTH'(1)) : (div_q - WIDTH'(1));
  assign cnt_en_c       = (state_q == ST_RUN) && !stop_i;

  load_down_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (cnt_load_c),
    .load_val_i (cnt_load_val_c),
    .en_i       (cnt_en_c),
    .cnt_o      (cnt_o),
    .zero_o     (cnt_zero_c)
  );

  // Next-state logic for the FSM, latched run parameters and period count.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    div_d     = div_q;
    periods_d = periods_q;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          if (div_i != '0) begin
            state_d   = ST_RUN;
            div_d     = div_i;
            mode_d    = mode_e'(mode_i);
            periods_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (cnt_zero_c) begin
          periods_d = periods_q + WIDTH'(1);
          if (mode_q == MODE_ONESHOT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_ONESHOT;
      div_q     <= '0;
      periods_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      periods_q <= periods_d;
      err_q     <= err_d;
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE) && !stop_i;
  assign err_o     = err_q;
  assign periods_o = periods_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scenario bench for div_ctrl: expected per-cycle outputs are queued as stimulus is driven.
`timescale 1ns/1ps
module tb_div_ctrl;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic         busy;
    logic         tick;
    logic         done;
    logic         err;
    logic [W-1:0] cnt;
    logic [W-1:0] per;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] div = '0;
  logic         busy_o, tick_o, done_o, err_o;
  logic [W-1:0] cnt_o, periods_o;

  obs_t         exp_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_cnt = '0;
  logic [W-1:0] exp_per = '0;

  div_ctrl #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (start),
    .stop_i    (stop),
    .mode_i    (mode),
    .div_i     (div),
    .busy_o    (busy_o),
    .tick_o    (tick_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .cnt_o     (cnt_o),
    .periods_o (periods_o)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic b, input logic t, input logic d, input logic e,
                              input logic [W-1:0] c, input logic [W-1:0] p);
    mk = {b, t, d, e, c, p};
  endfunction

  function automatic obs_t sample();
    sample = {busy_o, tick_o, done_o, err_o, cnt_o, periods_o};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic p, input logic m, input logic [W-1:0] d);
    start = s;
    stop  = p;
    mode  = m;
    div   = d;
  endtask

  task automatic test_reset();
    obs_t act, e;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, W'(5));
    next_cycle();
    next_cycle();
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0));
    #1;
    act = sample();
    e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL reset: got b%b t%b d%b e%b cnt=%0d per=%0d, want b%b t%b d%b e%b cnt=%0d per=%0d",
               act.busy, act.tick, act.done, act.err, act.cnt, act.per,
               e.busy, e.tick, e.done, e.err, e.cnt, e.per);
    end
    next_cycle();
    exp_cnt = '0;
    exp_per = '0;
  endtask

  // One-shot N=4 straight out of reset; start/div/mode changes during the run are ignored.
  task automatic test_oneshot();
    obs_t act, e;
    int n = 4;
    rst_n = 1'b1;
    for (int c = 0; c <= n + 2; c++) begin
      if (c == 0) begin
        drive(1'b1, 1'b0, 1'b0, W'(n));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, exp_cnt, exp_per));
      end else if (c <= n) begin
        drive(1'b1, 1'b0, 1'b1, W'(9));
        exp_q.push_back(mk(1'b1, c == n, 1'b0, 1'b0, W'(n - c), '0));
      end else if (c == n + 1) begin
        drive(1'b1, 1'b0, 1'b1, W'(9));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, '0, W'(1)));
      end else begin
        drive(1'b0, 1'b0, 1'b0, '0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, '0, W'(1)));
      end
      #1;
      act = sample();
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL oneshot c=%0d: got b%b t%b d%b e%b cnt=%0d per=%0d, want b%b t%b d%b e%b cnt=%0d per=%0d",
                 c, act.busy, act.tick, act.done, act.err, act.cnt, act.per,
                 e.busy, e.tick, e.done, e.err, e.cnt, e.per);
      end
      next_cycle();
    end
    exp_cnt = '0;
    exp_per = W'(1);
  endtask

  // Periodic N=3 for 10 cycles, then stop; cnt holds in IDLE afterwards.
  task automatic test_periodic();
    obs_t act, e;
    int n = 3;
    int cv;
    for (int c = 0; c <= 13; c++) begin
      if (c == 0) begin
        drive(1'b1, 1'b0, 1'b1, W'(n));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, exp_cnt, exp_per));
      end else if (c <= 10) begin
        drive(1'b0, 1'b0, 1'b0, W'(7));
        cv = (n - 1) - ((c - 1) % n);
        exp_q.push_back(mk(1'b1, cv == 0, 1'b0, 1'b0, W'(cv), W'((c - 1) / n)));
      end else if (c == 11) begin
        drive(1'b0, 1'b1, 1'b0, '0);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, W'(1), W'(3)));
      end else begin
        drive(1'b0, 1'b0, 1'b0, '0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, W'(1), W'(3)));
      end
      #1;
      act = sample();
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL periodic c=%0d: got b%b t%b d%b e%b cnt=%0d per=%0d, want b%b t%b d%b e%b cnt=%0d per=%0d",
                 c, act.busy, act.tick, act.done, act.err, act.cnt, act.per,
                 e.busy, e.tick, e.done, e.err, e.cnt, e.per);
      end
      next_cycle();
    end
    exp_cnt = W'(1);
    exp_per = W'(3);
  endtask

  // Zero ratio pulses err once; start+stop together (with or without zero ratio) does nothing.
  task automatic test_err();
    obs_t act, e;
    for (int c = 0; c <= 5; c++) begin
      unique case (c)
        0:       drive(1'b1, 1'b0, 1'b1, '0);
        2:       drive(1'b1, 1'b1, 1'b0, W'(7));
        4:       drive(1'b1, 1'b1, 1'b1, '0);
        default: drive(1'b0, 1'b0, 1'b0, '0);
      endcase
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, c == 1, exp_cnt, exp_per));
      #1;
      act = sample();
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL err c=%0d: got b%b t%b d%b e%b cnt=%0d per=%0d, want b%b t%b d%b e%b cnt=%0d per=%0d",
                 c, act.busy, act.tick, act.done, act.err, act.cnt, act.per,
                 e.busy, e.tick, e.done, e.err, e.cnt, e.per);
      end
      next_cycle();
    end
  endtask

  // Stop at cnt=0 in periodic N=5, then a one-shot N=2 stopped during DONE.
  task automatic test_stop();
    obs_t act, e;
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) begin
        drive(1'b1, 1'b0, 1'b1, W'(5));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, exp_cnt, exp_per));
      end else if (c <= 4) begin
        drive(1'b0, 1'b0, 1'b0, '0);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, W'(5 - c), '0));
      end else if (c == 5) begin
        drive(1'b0, 1'b1, 1'b0, '0);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, '0, '0));
      end else if (c == 6) begin
        drive(1'b1, 1'b0, 1'b0, W'(2));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0));
      end else if (c == 7) begin
        drive(1'b0, 1'b0, 1'b0, '0);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, W'(1), '0));
      end else if (c == 8) begin
        drive(1'b0, 1'b0, 1'b0, '0);
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, '0, '0));
      end else if (c == 9) begin
        drive(1'b0, 1'b1, 1'b0, '0);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, '0, W'(1)));
      end else begin
        drive(1'b0, 1'b0, 1'b0, '0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, '0, W'(1)));
      end
      #1;
      act = sample();
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL stop c=%0d: got b%b t%b d%b e%b cnt=%0d per=%0d, want b%b t%b d%b e%b cnt=%0d per=%0d",
                 c, act.busy, act.tick, act.done, act.err, act.cnt, act.per,
                 e.busy, e.tick, e.done, e.err, e.cnt, e.per);
      end
      next_cycle();
    end
    exp_cnt = '0;
    exp_per = W'(1);
  endtask

  // Periodic N=1 for 300 cycles: tick every cycle, periods wraps past 255.
  task automatic test_wrap();
    obs_t act, e;
    for (int c = 0; c <= 302; c++) begin
      if (c == 0) begin
        drive(1'b1, 1'b0, 1'b1, W'(1));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, exp_cnt, exp_per));
      end else if (c <= 300) begin
        drive(1'b0, 1'b0, 1'b1, W'(1));
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, '0, W'((c - 1) % 256)));
      end else if (c == 301) begin
        drive(1'b0, 1'b1, 1'b0, '0);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, '0, W'(44)));
      end else begin
        drive(1'b0, 1'b0, 1'b0, '0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, '0, W'(44)));
      end
      #1;
      act = sample();
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL wrap c=%0d: got b%b t%b d%b e%b cnt=%0d per=%0d, want b%b t%b d%b e%b cnt=%0d per=%0d",
                 c, act.busy, act.tick, act.done, act.err, act.cnt, act.per,
                 e.busy, e.tick, e.done, e.err, e.cnt, e.per);
      end
      next_cycle();
    end
    exp_cnt = '0;
    exp_per = W'(44);
  endtask

  // Reset mid-run (N=6), immediate restart, and restarts re-presented while running.
  task automatic test_reset_midrun();
    obs_t act, e;
    for (int c = 0; c <= 13; c++) begin
      rst_n = (c != 4);
      if (c == 0) begin
        drive(1'b1, 1'b0, 1'b1, W'(6));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, exp_cnt, exp_per));
      end else if (c <= 4) begin
        drive(c == 4, 1'b0, 1'b1, W'(6));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, W'(6 - c), '0));
      end else if (c == 5) begin
        drive(1'b1, 1'b0, 1'b0, W'(6));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0));
      end else if (c <= 11) begin
        drive(c <= 7, 1'b0, 1'b1, W'(6));
        exp_q.push_back(mk(1'b1, c == 11, 1'b0, 1'b0, W'(11 - c), '0));
      end else if (c == 12) begin
        drive(1'b0, 1'b0, 1'b0, '0);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, '0, W'(1)));
      end else begin
        drive(1'b0, 1'b0, 1'b0, '0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, '0, W'(1)));
      end
      #1;
      act = sample();
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL reset_midrun c=%0d: got b%b t%b d%b e%b cnt=%0d per=%0d, want b%b t%b d%b e%b cnt=%0d per=%0d",
                 c, act.busy, act.tick, act.done, act.err, act.cnt, act.per,
                 e.busy, e.tick, e.done, e.err, e.cnt, e.per);
      end
      next_cycle();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_err();
    test_stop();
    test_wrap();
    test_reset_midrun();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
